// File: rtl/if_fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int          AddrWidth = 17;
  localparam logic [31:0] ZeroWord  = 32'h0;
  localparam logic        Enable    = 1'b1;
  localparam logic        Disable   = 1'b0;

  typedef enum logic [2:0] {
    LOOKUP = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    DONE   = 3'd3,
    FLUSH  = 3'd4
  } state_t;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: icache lookup, serial byte fill from the memory
// controller on a miss, branch redirect and downstream stall handling.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 branch_i,
  input  logic [31:0]          branch_target_i,
  output logic                 ic_read_o,
  output logic [AddrWidth-1:0] ic_read_addr_o,
  input  logic                 ic_hit_i,
  input  logic [31:0]          ic_inst_i,
  output logic                 ic_write_o,
  output logic [AddrWidth-1:0] ic_write_addr_o,
  output logic [31:0]          ic_write_inst_o,
  output logic                 mem_req_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  input  logic                 mem_busy_i,
  input  logic                 mem_rvalid_i,
  input  logic [7:0]           mem_data_i,
  output logic                 inst_valid_o,
  output logic [31:0]          inst_o,
  output logic [31:0]          pc_o
);

  state_t      state, next_state;
  logic [31:0] pc;
  logic [1:0]  cnt;
  logic [31:0] fill_buf;
  logic        written;

  logic hit_take, done_take, accept;

  assign hit_take  = (state == LOOKUP) && ic_hit_i && !branch_i && !stall_i;
  assign done_take = (state == DONE) && !branch_i && !stall_i;
  assign accept    = mem_req_o && !mem_busy_i;

  assign ic_read_addr_o  = pc[AddrWidth-1:0];
  assign ic_write_addr_o = pc[AddrWidth-1:0];
  assign ic_write_inst_o = fill_buf;
  assign mem_addr_o      = pc[AddrWidth-1:0] + AddrWidth'(cnt);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= LOOKUP;
    else     state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      LOOKUP: if (!branch_i && !ic_hit_i) next_state = REQ;
      REQ: begin
        if (branch_i)    next_state = LOOKUP;
        else if (accept) next_state = WAIT;
      end
      WAIT: begin
        // A byte returning in the redirect cycle leaves nothing to flush.
        if (branch_i)          next_state = mem_rvalid_i ? LOOKUP : FLUSH;
        else if (mem_rvalid_i) next_state = (cnt == 2'd3) ? DONE : REQ;
      end
      DONE:  if (branch_i || !stall_i) next_state = LOOKUP;
      FLUSH: if (mem_rvalid_i) next_state = LOOKUP;
      default: next_state = LOOKUP;
    endcase
  end

  always_comb begin
    ic_read_o  = Disable;
    mem_req_o  = Disable;
    ic_write_o = Disable;
    unique case (state)
      LOOKUP:  ic_read_o  = Enable;
      REQ:     mem_req_o  = Enable;
      DONE:    ic_write_o = !written && !branch_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      cnt      <= 2'd0;
      fill_buf <= ZeroWord;
      written  <= 1'b0;
    end else begin
      // Marks the fill as committed so a stalled DONE writes only once.
      written <= (state == DONE);
      if (branch_i)                   pc <= branch_target_i & ~32'h3;
      else if (hit_take || done_take) pc <= pc + 32'd4;
      if (state == LOOKUP && !ic_hit_i) cnt <= 2'd0;
      if (state == WAIT && mem_rvalid_i && !branch_i) begin
        fill_buf[{cnt, 3'b000} +: 8] <= mem_data_i;
        if (cnt != 2'd3) cnt <= cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_valid_o <= 1'b0;
      inst_o       <= ZeroWord;
      pc_o         <= ZeroWord;
    end else if (branch_i) begin
      inst_valid_o <= 1'b0;
    end else if (!stall_i) begin
      if (hit_take) begin
        inst_valid_o <= 1'b1;
        inst_o       <= ic_inst_i;
        pc_o         <= pc;
      end else if (done_take) begin
        inst_valid_o <= 1'b1;
        inst_o       <= fill_buf;
        pc_o         <= pc;
      end else begin
        inst_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: icache and byte-memory models, directed
// fetch scenarios, a monitor that pops expected instructions on handshake.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        ic_read_o;
  logic [16:0] ic_read_addr_o;
  logic        ic_hit_i;
  logic [31:0] ic_inst_i;
  logic        ic_write_o;
  logic [16:0] ic_write_addr_o;
  logic [31:0] ic_write_inst_o;
  logic        mem_req_o;
  logic [16:0] mem_addr_o;
  logic        mem_busy_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [7:0]  mem_data_i = 8'h0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;

  if_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_i(branch_i),
    .branch_target_i(branch_target_i),
    .ic_read_o(ic_read_o), .ic_read_addr_o(ic_read_addr_o),
    .ic_hit_i(ic_hit_i), .ic_inst_i(ic_inst_i),
    .ic_write_o(ic_write_o), .ic_write_addr_o(ic_write_addr_o),
    .ic_write_inst_o(ic_write_inst_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_busy_i(mem_busy_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_data_i(mem_data_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // icache model: word-indexed by addr[11:2]
  logic        ic_valid [0:1023];
  logic [31:0] ic_data  [0:1023];
  assign ic_hit_i  = ic_read_o && ic_valid[ic_read_addr_o[11:2]];
  assign ic_inst_i = ic_data[ic_read_addr_o[11:2]];

  // Memory controller model knobs, set by the stimulus process
  logic [7:0]  mem [0:4095];
  int          lat = 1;
  int          busy_left = 0;
  logic [16:0] busy_addr = '1;

  int          wr_count = 0;
  logic [16:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  initial begin : mem_ctrl
    int          pend;
    logic [16:0] pend_addr;
    logic        was_busy;
    for (int a = 0; a < 4096; a++) mem[a] = 8'(a) ^ 8'h5A;
    {mem[0], mem[1], mem[2], mem[3]}                 = {8'h13, 8'h05, 8'h10, 8'h00};
    {mem[256], mem[257], mem[258], mem[259]}         = {8'h93, 8'h00, 8'h10, 8'h00};
    {mem[768], mem[769], mem[770], mem[771]}         = {8'h37, 8'h12, 8'h00, 8'h00};
    {mem[1024], mem[1025], mem[1026], mem[1027]}     = {8'h6f, 8'h00, 8'h00, 8'h00};
    pend = 0;
    pend_addr = '0;
    was_busy = 1'b0;
    forever begin
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      if (was_busy) begin
        check("busy_hold_req", 32'(mem_req_o), 32'd1);
        check("busy_hold_addr", 32'(mem_addr_o), 32'(busy_addr));
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_rvalid_i = 1'b1;
          mem_data_i   = mem[pend_addr[11:0]];
        end
      end
      mem_busy_i = mem_req_o && (mem_addr_o == busy_addr) && (busy_left > 0);
      if (mem_busy_i) busy_left--;
      was_busy = mem_busy_i;
      if (mem_req_o && !mem_busy_i) begin
        pend      = lat;
        pend_addr = mem_addr_o;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    for (int i = 0; i < 1024; i++) begin
      ic_valid[i] = 1'b0;
      ic_data[i]  = 32'h0;
    end
    for (int i = 0; i < 4; i++) begin
      ic_valid[16+i] = 1'b1;
      ic_data[16+i]  = 32'hC0DE_0040 + 32'(4 * i);
    end
    forever begin
      @(negedge clk);
      if (!rst && ic_write_o) begin
        wr_count++;
        wr_addr = ic_write_addr_o;
        wr_data = ic_write_inst_o;
        ic_valid[ic_write_addr_o[11:2]] = 1'b1;
        ic_data[ic_write_addr_o[11:2]]  = ic_write_inst_o;
      end
      if (!rst && inst_valid_o && !stall_i) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_inst: actual pc %h required no instruction", pc_o);
        end else begin
          e = sb.pop_front();
          check("pc_o", pc_o, e.pc);
          check("inst_o", inst_o, e.inst);
          if (e.cyc >= 0) check("latency_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the first non-reset cycle, which looks up RESET_PC.
  task automatic do_reset();
    rst      = 1'b1;
    branch_i = 1'b0;
    stall_i  = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
  endtask

  // Returns in the cycle that looks up the target.
  task automatic start_at(input logic [31:0] target);
    do_reset();
    branch_i        = 1'b1;
    branch_target_i = target;
    tick();
    branch_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: actual %0d pending required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_req(input logic [16:0] addr, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_req_o && mem_addr_o == addr) && n < budget);
    if (!(mem_req_o && mem_addr_o == addr)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_req_timeout: actual no request required addr %h", addr);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(inst_valid_o), 32'd0);
    check({tag, "_inst"}, inst_o, 32'h0);
    check({tag, "_pc_o"}, pc_o, 32'h0);
    check({tag, "_mem_req"}, 32'(mem_req_o), 32'd0);
    check({tag, "_ic_write"}, 32'(ic_write_o), 32'd0);
    check({tag, "_lookup_addr"}, 32'(ic_read_addr_o), 32'h0);
  endtask

  initial begin : stimulus
    int t0;
    int wc0;

    // Cold miss from reset, L=1: 10 cycles lookup-to-valid
    do_reset();
    check_reset_state("reset");
    check("reset_ic_read", 32'(ic_read_o), 32'd1);
    wc0 = wr_count;
    t0  = cyc;
    sb.push_back('{pc: 32'h0, inst: 32'h0010_0513, cyc: t0 + 10});
    drain(40);
    check("miss_fill_count", 32'(wr_count - wc0), 32'd1);
    check("miss_fill_addr", 32'(wr_addr), 32'h0);
    check("miss_fill_data", wr_data, 32'h0010_0513);

    // All-hit straight line: one instruction per cycle
    start_at(32'h40);
    t0 = cyc;
    for (int i = 0; i < 4; i++)
      sb.push_back('{pc: 32'h40 + 32'(4 * i), inst: 32'hC0DE_0040 + 32'(4 * i), cyc: t0 + 1 + i});
    drain(20);

    // Stall for 3 cycles while 0x44 is presented
    start_at(32'h40);
    t0 = cyc;
    sb.push_back('{pc: 32'h40, inst: 32'hC0DE_0040, cyc: t0 + 1});
    sb.push_back('{pc: 32'h44, inst: 32'hC0DE_0044, cyc: t0 + 5});
    sb.push_back('{pc: 32'h48, inst: 32'hC0DE_0048, cyc: t0 + 6});
    sb.push_back('{pc: 32'h4C, inst: 32'hC0DE_004C, cyc: t0 + 7});
    tick();
    tick();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_valid", 32'(inst_valid_o), 32'd1);
      check("stall_hold_pc_o", pc_o, 32'h44);
      check("stall_pc_frozen", 32'(ic_read_addr_o), 32'h48);
    end
    stall_i = 1'b0;
    drain(20);

    // Redirect to 0x103 while byte 2 of the 0x200 fill is outstanding
    lat = 3;
    start_at(32'h200);
    wc0 = wr_count;
    wait_req(17'h202, 100);
    tick();
    branch_i        = 1'b1;
    branch_target_i = 32'h103;
    tick();
    branch_i = 1'b0;
    sb.push_back('{pc: 32'h100, inst: 32'h0010_0093, cyc: -1});
    drain(80);
    check("flush_fill_count", 32'(wr_count - wc0), 32'd1);
    check("flush_fill_addr", 32'(wr_addr), 32'h100);

    // Busy for 5 cycles on byte 1: latency 10 + 5
    lat       = 1;
    busy_addr = 17'h301;
    busy_left = 5;
    start_at(32'h300);
    t0 = cyc;
    sb.push_back('{pc: 32'h300, inst: 32'h0000_1237, cyc: t0 + 15});
    drain(40);
    check("busy_consumed", 32'(busy_left), 32'd0);
    busy_addr = '1;

    // Fill completes under stall: single icache write, delivered on release
    start_at(32'h400);
    stall_i = 1'b1;
    wc0 = wr_count;
    repeat (20) tick();
    check("stalled_fill_count", 32'(wr_count - wc0), 32'd1);
    check("stalled_fill_addr", 32'(wr_addr), 32'h400);
    check("stalled_no_valid", 32'(inst_valid_o), 32'd0);
    stall_i = 1'b0;
    sb.push_back('{pc: 32'h400, inst: 32'h0000_006F, cyc: cyc + 1});
    drain(10);
    check("stalled_fill_count_after", 32'(wr_count - wc0), 32'd1);

    // Reset after activity restores the reset state
    do_reset();
    check_reset_state("rereset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
